// File: rtl/multicycle_control_fsm.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with I/O handshake stall,
// configurable data-memory wait and a retired-instruction counter. Outputs are registered.
module multicycle_control_fsm #(
  parameter int MEM_LAT     = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             io_ack,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             jump,
  output logic             jump_r,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_write,
  output logic             op_io,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [4:0]       alu_op,
  output logic             input_inst,
  output logic             output_inst,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h0A;
  localparam logic [5:0] OP_SW   = 6'h0B;
  localparam logic [5:0] OP_J    = 6'h0F;
  localparam logic [5:0] OP_JAL  = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h12;
  localparam logic [5:0] OP_IN   = 6'h13;
  localparam logic [5:0] OP_OUT  = 6'h14;
  localparam logic [5:0] OP_LAST = 6'h1A;
  localparam logic [5:0] FN_JR   = 6'h0C;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_IO_WAIT = 3'd5, S_HALT = 3'd6
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       jump;
    logic       jump_r;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       op_io;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [4:0] alu_op;
    logic       input_inst;
    logic       output_inst;
  } ctrl_t;

  function automatic logic is_branch(input logic [5:0] op);
    return (op >= 6'h05) && (op <= 6'h09);
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    return ((op >= 6'h01) && (op <= 6'h04)) || ((op >= 6'h0A) && (op <= 6'h0E)) ||
           ((op >= 6'h15) && (op <= 6'h1A));
  endfunction

  function automatic logic goes_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic goes_wb(input logic [5:0] op, input logic [5:0] fn);
    return ((op == OP_R) && (fn != FN_JR)) || (uses_imm(op) && !goes_mem(op)) || (op == OP_JAL);
  endfunction

  function automatic logic [4:0] alu_r(input logic [5:0] fn);
    case (fn)
      6'h02: return 5'h01;  6'h03: return 5'h03;  6'h04: return 5'h02;
      6'h05: return 5'h04;  6'h06: return 5'h05;  6'h07: return 5'h06;
      6'h08: return 5'h07;  6'h09: return 5'h08;  6'h0A: return 5'h09;
      6'h0B: return 5'h0F;  6'h0D: return 5'h11;  6'h0E: return 5'h12;
      6'h0F: return 5'h13;  6'h10: return 5'h14;  6'h11: return 5'h15;
      default: return 5'h00;
    endcase
  endfunction

  function automatic logic [4:0] alu_i(input logic [5:0] op);
    case (op)
      6'h02: return 5'h03;  6'h03: return 5'h02;  6'h04: return 5'h04;
      6'h0C: return 5'h05;  6'h0D: return 5'h07;  6'h0E: return 5'h0F;
      6'h15: return 5'h10;  6'h16: return 5'h11;  6'h17: return 5'h12;
      6'h18: return 5'h13;  6'h19: return 5'h14;  6'h1A: return 5'h15;
      6'h05: return 5'h0A;  6'h06: return 5'h0B;  6'h07: return 5'h0C;
      6'h08: return 5'h0D;  6'h09: return 5'h0E;
      default: return 5'h00;
    endcase
  endfunction

  // Control word for a given state; mem_last/io_rise say whether that cycle ends the instruction.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] fn,
                                   input logic mem_last, input logic io_rise);
    ctrl_t c;
    c = '0;
    if (s == S_EXEC || s == S_MEM || s == S_WB) begin
      c.alu_src = uses_imm(op);
      c.alu_op  = (op == OP_R) ? alu_r(fn) : alu_i(op);
    end
    case (s)
      S_FETCH: c.ir_write = 1'b1;
      S_EXEC: begin
        c.branch = is_branch(op);
        if (!goes_mem(op) && !goes_wb(op, fn)) begin
          c.pc_write = 1'b1;
          c.jump     = (op == OP_J);
          c.jump_r   = (op == OP_R) && (fn == FN_JR);
        end
      end
      S_MEM: begin
        c.mem_write = (op == OP_SW);
        c.pc_write  = (op == OP_SW) && mem_last;
      end
      S_WB: begin
        c.pc_write  = 1'b1;
        c.reg_write = 1'b1;
        if (op == OP_JAL) begin
          c.jump = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b01;
        end else if (op == OP_IN) begin
          c.input_inst = 1'b1; c.reg_dst = 2'b01; c.mem_to_reg = 2'b11;
        end else if (op == OP_LW) begin
          c.reg_dst = 2'b00; c.mem_to_reg = 2'b00;
        end else begin
          c.reg_dst = (op == OP_R) ? 2'b11 : 2'b00; c.mem_to_reg = 2'b10;
        end
      end
      S_IO_WAIT: begin
        if (op == OP_IN) begin
          c.input_inst = 1'b1;
        end else begin
          c.output_inst = 1'b1; c.op_io = 1'b1; c.pc_write = io_rise;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t                 state_q, state_d;
  logic [5:0]             op_q, op_d, funct_q, funct_d;
  logic [3:0]             memcnt_q, memcnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   halted_q, illegal_q;
  logic [CNT_W-1:0]       retired_q;
  ctrl_t                  ctrl_q, ctrl_d;
  logic                   rise_now, rise_next;

  // rise_next predicts next cycle's edge detect so a registered pc_write lands on the exit cycle.
  assign rise_now  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign rise_next = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    funct_d  = funct_q;
    memcnt_d = memcnt_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (opcode == OP_HALT)                         state_d = S_HALT;
        else if (opcode == OP_IN || opcode == OP_OUT)  state_d = S_IO_WAIT;
        else                                           state_d = S_EXEC;
      end
      S_EXEC: begin
        if (goes_mem(op_q)) begin
          state_d  = S_MEM;
          memcnt_d = 4'(MEM_LAT - 1);
        end else if (goes_wb(op_q, funct_q)) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (memcnt_q == 4'd0) state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        else                  memcnt_d = memcnt_q - 4'd1;
      end
      S_WB:      state_d = S_FETCH;
      S_IO_WAIT: if (rise_now) state_d = (op_q == OP_IN) ? S_WB : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = decode(state_d, op_d, funct_d, memcnt_d == 4'd0, rise_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      memcnt_q  <= '0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      memcnt_q  <= memcnt_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], io_ack};
      prev_q    <= sync_q[SYNC_STAGES-1];
      halted_q  <= halted_q | (state_d == S_HALT);
      illegal_q <= illegal_q | ((state_q == S_DECODE) && (opcode > OP_LAST));
      retired_q <= retired_q + CNT_W'(ctrl_d.pc_write);
      ctrl_q    <= ctrl_d;
    end
  end

  assign ir_write    = ctrl_q.ir_write;
  assign pc_write    = ctrl_q.pc_write;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign jump_r      = ctrl_q.jump_r;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_write   = ctrl_q.mem_write;
  assign op_io       = ctrl_q.op_io;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_op      = ctrl_q.alu_op;
  assign input_inst  = ctrl_q.input_inst;
  assign output_inst = ctrl_q.output_inst;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule
